// File: rtl/wb_host_master.sv
// Single-outstanding command/response to Wishbone classic master bridge.
// Optional bus watchdog enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  rst_sync_reg;
    logic        rst_n;
    logic        we_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  sel_reg;
    logic [31:0] rsp_dat_reg;
    logic        rsp_err_reg;
    logic        tmo_hit;

    // Reset asserts immediately but releases only after two clock edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

`ifdef WB_HOST_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_reg;

    // Held at zero outside BUS so every bus cycle starts counting from 0.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= 16'd0;
        end else if (state_reg != BUS) begin
            tmo_cnt_reg <= 16'd0;
        end else if (!wbm_ack_i && !wbm_err_i) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end

    assign tmo_hit = (state_reg == BUS) && (tmo_cnt_reg == TMO_LAST);
`else
    // No watchdog: legal TIMEOUT_CYCLES is never 0, so BUS waits indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (wbm_ack_i || wbm_err_i || tmo_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Error beats ack, and a real termination beats the watchdog.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            we_reg      <= 1'b0;
            adr_reg     <= 32'd0;
            dat_reg     <= 32'd0;
            sel_reg     <= 4'd0;
            rsp_dat_reg <= 32'd0;
            rsp_err_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && cmd_valid_i) begin
                we_reg  <= cmd_we_i;
                adr_reg <= cmd_adr_i;
                dat_reg <= cmd_dat_i;
                sel_reg <= cmd_sel_i;
            end
            if (state_reg == BUS) begin
                if (wbm_err_i) begin
                    rsp_err_reg <= 1'b1;
                    rsp_dat_reg <= 32'd0;
                end else if (wbm_ack_i) begin
                    rsp_err_reg <= 1'b0;
                    rsp_dat_reg <= we_reg ? 32'd0 : wbm_dat_i;
                end else if (tmo_hit) begin
                    rsp_err_reg <= 1'b1;
                    rsp_dat_reg <= 32'd0;
                end
            end
        end
    end

    assign wbm_we_o  = we_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign wbm_sel_o = sel_reg;
    assign rsp_dat_o = rsp_dat_reg;
    assign rsp_err_o = rsp_err_reg;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: vector table of bus transactions plus
// hand-written backpressure, timeout and mid-bus reset sequences.
module tb_wb_host_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic [31:0] wbm_dat_i;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (wb_rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        tick();
        // Scramble command inputs to prove the bus side uses registered copies.
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~we;
        cmd_adr_i   = ~adr;
        cmd_dat_i   = ~dat;
        cmd_sel_i   = ~sel;
    endtask

    task automatic consume(input string tag);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, "_rsp_valid_clear"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_ready_again"}, 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        chk({t, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        issue(v.we, v.adr, v.dat, v.sel);
        chk({t, "_we"}, 32'(wbm_we_o), 32'(v.we));
        chk({t, "_dat"}, wbm_dat_o, v.dat);
        chk({t, "_sel"}, 32'(wbm_sel_o), 32'(v.sel));
        for (int w = 0; w <= v.waits; w++) begin
            chk($sformatf("%s_cyc_c%0d", t, w), 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
            chk($sformatf("%s_adr_c%0d", t, w), wbm_adr_o, v.adr);
            chk($sformatf("%s_busy_c%0d", t, w), 32'({cmd_ready_o, rsp_valid_o}), 32'd0);
            if (w == v.waits) begin
                wbm_ack_i = v.ack;
                wbm_err_i = v.err;
                wbm_dat_i = v.rdata;
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'hFFFF_FFFF;
        chk({t, "_cyc_drop"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        chk({t, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({t, "_rsp_dat"}, rsp_dat_o, v.exp_dat);
        chk({t, "_rsp_err"}, 32'(rsp_err_o), 32'(v.exp_err));
        chk({t, "_no_accept"}, 32'(cmd_ready_o), 32'd0);
        consume(t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        we    adr           dat           sel   w  ack   err   rdata         exp_dat       exp_err
        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 1'b0, 32'hAAAA_5555, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 3, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'h3, 0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 32'h1000_0000, 32'h0102_0304, 4'h1, 2, 1'b0, 1'b1, 32'h7777_7777, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h2000_0010, 32'h0000_0000, 4'hC, 1, 1'b1, 1'b0, 32'h8000_0001, 32'h8000_0001, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 0, 1'b0, 1'b1, 32'h55AA_55AA, 32'h0000_0000, 1'b1};
        // Ack arrives in the last cycle before the watchdog would fire.
        vecs[6] = '{1'b0, 32'h6000_0000, 32'h0000_0000, 4'hF, TMO - 1, 1'b1, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0};

        wb_rst_ni   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'd0;
        cmd_dat_i   = 32'd0;
        cmd_sel_i   = 4'd0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        wbm_dat_i   = 32'd0;
        tick();
        tick();

        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_cyc_stb_we", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);

        wb_rst_ni = 1'b1;
        tick();
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], i);
        end

        // Response backpressure with a second command waiting.
        issue(1'b0, 32'h4000_0000, 32'd0, 4'hF);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_CAFE;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h4000_0004;
        cmd_dat_i   = 32'h1122_3344;
        cmd_sel_i   = 4'hF;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_cmd_ready_c%0d", c), 32'(cmd_ready_o), 32'd0);
            chk($sformatf("bp_rsp_valid_c%0d", c), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("bp_rsp_dat_c%0d", c), rsp_dat_o, 32'h0BAD_CAFE);
            chk($sformatf("bp_cyc_c%0d", c), 32'(wbm_cyc_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_idle_ready", 32'(cmd_ready_o), 32'd1);
        chk("bp_idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        cmd_valid_i = 1'b0;
        chk("bp_second_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("bp_second_adr", wbm_adr_o, 32'h4000_0004);
        chk("bp_second_dat", wbm_dat_o, 32'h1122_3344);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("bp_second_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd2);
        chk("bp_second_dat0", rsp_dat_o, 32'd0);
        consume("bp2");

        // Silent slave.
        issue(1'b0, 32'h5000_0000, 32'd0, 4'hF);
`ifdef WB_HOST_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (wbm_cyc_o && n < 20) begin
                n++;
                tick();
            end
            chk("tmo_bus_cycles", 32'(n), 32'(TMO));
            chk("tmo_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("tmo_rsp_err", 32'(rsp_err_o), 32'd1);
            chk("tmo_rsp_dat", rsp_dat_o, 32'd0);
            consume("tmo");
        end
        run_txn(vecs[6], 6);
`else
        for (int c = 0; c < 1000; c++) begin
            tick();
        end
        chk("notmo_cyc_held", 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
        chk("notmo_no_rsp", 32'(rsp_valid_o), 32'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_BEEF;
        tick();
        wbm_ack_i = 1'b0;
        chk("notmo_late_ack", rsp_dat_o, 32'h0000_BEEF);
        chk("notmo_late_err", 32'({rsp_valid_o, rsp_err_o}), 32'd2);
        consume("notmo");
        run_txn(vecs[6], 6);
`endif

        // Reset pulse in the middle of a bus cycle.
        issue(1'b1, 32'h7000_0000, 32'h9999_0000, 4'hF);
        chk("mid_rst_pre_cyc", 32'(wbm_cyc_o), 32'd1);
        #2;
        wb_rst_ni = 1'b0;
        wbm_ack_i = 1'b1;
        #1;
        chk("mid_rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
        chk("mid_rst_adr", wbm_adr_o, 32'd0);
        tick();
        wbm_ack_i = 1'b0;
        wb_rst_ni = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h2000_0010;
        cmd_dat_i   = 32'd0;
        cmd_sel_i   = 4'hC;
        tick();
        chk("rel_edge1_cyc", 32'({wbm_cyc_o, rsp_valid_o}), 32'd0);
        tick();
        chk("rel_edge2_cyc", 32'({wbm_cyc_o, rsp_valid_o}), 32'd0);
        tick();
        cmd_valid_i = 1'b0;
        chk("rel_edge3_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("rel_edge3_adr", wbm_adr_o, 32'h2000_0010);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h8000_0001;
        tick();
        wbm_ack_i = 1'b0;
        chk("post_rst_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd2);
        chk("post_rst_dat", rsp_dat_o, 32'h8000_0001);
        consume("post_rst");

        run_txn(vecs[1], 11);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
